logs_seq: RTL and testbench

- Note sequencer/scheduler that drives one logs_nco voice.
- Holds a small programmable note table of frequency word plus duration per entry.
- Generates the NCO `step` strobe through a prescaler, presents the current frequency word, and walks the table once or in a loop.
- Holds the NCO in reset while idle; pulses `done` at the end of a one-shot sequence.

---
 rtl/logs_seq.sv | 199 +++++++++++++++++++
 tb/tb_logs_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logs_seq.sv
// logs_seq: note sequencer driving one logs_nco voice.
// Walks a small programmable table of {frequency word, duration}, generates
// the NCO step strobe through a prescaler and holds the NCO in reset while idle.
module logs_seq #(
  parameter int unsigned N       = 5,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DUR_W   = 4,
  parameter int unsigned BEAT_W  = 4,
  parameter int unsigned PRESC_W = 8,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned FW     = N - 1,
  localparam int unsigned LW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [LW-1:0]      len,
  input  logic [PRESC_W-1:0] presc,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [FW-1:0]      wr_freq,
  input  logic [DUR_W-1:0]   wr_dur,
  output logic               step,
  output logic [FW-1:0]      freq_out,
  output logic               nco_reset,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      note_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_nx;

  logic [FW-1:0]      tbl_freq [DEPTH];
  logic [DUR_W-1:0]   tbl_dur  [DEPTH];

  logic [LW-1:0]      len_q,   len_nx;
  logic [PRESC_W-1:0] presc_q, presc_nx;
  logic [DUR_W-1:0]   dur_q,   dur_nx;
  logic [BEAT_W-1:0]  beat_q,  beat_nx;
  logic [PRESC_W-1:0] pcnt_q,  pcnt_nx;
  logic [AW-1:0]      note_nx;
  logic [FW-1:0]      freq_nx;
  logic               nco_rst_nx;
  logic               busy_nx;
  logic               done_nx;

  logic               beat_wrap_c;
  logic               more_notes_c;

  // Step strobe: last prescaler count of a PLAY cycle
  assign step         = (state_q == S_PLAY) && (pcnt_q == presc_q);
  assign beat_wrap_c  = step && (beat_q == {BEAT_W{1'b1}});
  assign more_notes_c = ({1'b0, note_idx} < (len_q - LW'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state, counter and output-register next values
  always_comb begin
    state_nx   = state_q;
    len_nx     = len_q;
    presc_nx   = presc_q;
    dur_nx     = dur_q;
    beat_nx    = beat_q;
    pcnt_nx    = pcnt_q;
    note_nx    = note_idx;
    freq_nx    = freq_out;
    nco_rst_nx = nco_reset;
    busy_nx    = busy;
    done_nx    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!stop && start && (len != '0)) begin
          state_nx = S_LOAD;
          len_nx   = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
          presc_nx = presc;
          note_nx  = '0;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else begin
          // Table is read before this edge's write lands, so a colliding write applies next time
          state_nx   = S_PLAY;
          freq_nx    = tbl_freq[note_idx];
          dur_nx     = tbl_dur[note_idx];
          beat_nx    = '0;
          pcnt_nx    = '0;
          nco_rst_nx = 1'b0;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else begin
          pcnt_nx = step ? '0 : pcnt_q + PRESC_W'(1);
          if (step) begin
            beat_nx = beat_q + BEAT_W'(1);
          end
          if (beat_wrap_c) begin
            if (dur_q != '0) begin
              dur_nx = dur_q - DUR_W'(1);
            end else if (more_notes_c) begin
              note_nx  = note_idx + AW'(1);
              state_nx = S_LOAD;
            end else if (loop) begin
              note_nx  = '0;
              state_nx = S_LOAD;
            end else begin
              state_nx = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Output registers follow the state being entered
    case (state_nx)
      S_IDLE: begin
        freq_nx    = '0;
        nco_rst_nx = 1'b1;
        busy_nx    = 1'b0;
      end
      S_DONE: begin
        freq_nx    = '0;
        nco_rst_nx = 1'b1;
        busy_nx    = 1'b0;
        done_nx    = 1'b1;
      end
      default: begin
        busy_nx = 1'b1;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      presc_q   <= '0;
      dur_q     <= '0;
      beat_q    <= '0;
      pcnt_q    <= '0;
      note_idx  <= '0;
      freq_out  <= '0;
      nco_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      len_q     <= len_nx;
      presc_q   <= presc_nx;
      dur_q     <= dur_nx;
      beat_q    <= beat_nx;
      pcnt_q    <= pcnt_nx;
      note_idx  <= note_nx;
      freq_out  <= freq_nx;
      nco_reset <= nco_rst_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Note table: cleared by reset, writable in any state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_freq[i] <= '0;
        tbl_dur[i]  <= '0;
      end
    end else if (wr_en) begin
      tbl_freq[wr_addr] <= wr_freq;
      tbl_dur[wr_addr]  <= wr_dur;
    end
  end

endmodule

// File: tb/tb_logs_seq.sv
// tb_logs_seq: directed test-plan scenarios followed by random traffic,
// every cycle compared against a note-timeline reference model.
module tb_logs_seq;

  localparam int unsigned N       = 5;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DUR_W   = 4;
  localparam int unsigned BEAT_W  = 1;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned AW      = 3;

  logic               clk = 1'b0;
  logic               rst_n, start, stop, loop, wr_en;
  logic [AW:0]        len;
  logic [PRESC_W-1:0] presc;
  logic [AW-1:0]      wr_addr;
  logic [N-2:0]       wr_freq;
  logic [DUR_W-1:0]   wr_dur;
  logic               step, nco_reset, busy, done;
  logic [N-2:0]       freq_out;
  logic [AW-1:0]      note_idx;

  always #5 clk = ~clk;

  logs_seq #(.N(N), .DEPTH(DEPTH), .DUR_W(DUR_W), .BEAT_W(BEAT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .len(len), .presc(presc), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_freq(wr_freq), .wr_dur(wr_dur), .step(step), .freq_out(freq_out),
    .nco_reset(nco_reset), .busy(busy), .done(done), .note_idx(note_idx)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;

  // Reference model: 0 idle, 1 load, 2 play, 3 done; m_el = PLAY cycles spent on this note
  int m_mode, m_len, m_presc, m_idx, m_el, m_nlen, m_freq, m_nco;
  int m_tf[DEPTH];
  int m_td[DEPTH];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_mode = 0; m_freq = 0; m_nco = 1; m_idx = 0; m_el = 0;
      m_len = 0; m_presc = 0; m_nlen = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_tf[i] = 0;
        m_td[i] = 0;
      end
      return;
    end
    case (m_mode)
      0: if (!stop && start && len != 0) begin
           m_mode  = 1;
           m_len   = (int'(len) > int'(DEPTH)) ? int'(DEPTH) : int'(len);
           m_presc = int'(presc);
           m_idx   = 0;
         end
      1: if (stop) m_mode = 0;
         else begin
           m_mode = 2;
           m_freq = m_tf[m_idx];
           m_nlen = (m_td[m_idx] + 1) * (1 << BEAT_W) * (m_presc + 1);
           m_el   = 0;
           m_nco  = 0;
         end
      2: if (stop) m_mode = 0;
         else begin
           m_el++;
           if (m_el == m_nlen) begin
             if (m_idx < m_len - 1) begin m_idx++; m_mode = 1; end
             else if (loop) begin m_idx = 0; m_mode = 1; end
             else m_mode = 3;
           end
         end
      default: m_mode = 0;
    endcase
    if (m_mode == 0 || m_mode == 3) begin
      m_freq = 0;
      m_nco  = 1;
    end
    if (wr_en) begin
      m_tf[wr_addr] = int'(wr_freq);
      m_td[wr_addr] = int'(wr_dur);
    end
  endtask

  task automatic check_all();
    int exp_step;
    exp_step = (m_mode == 2 && (m_el % (m_presc + 1)) == m_presc) ? 1 : 0;
    chk("step", int'(step), exp_step);
    chk("freq_out", int'(freq_out), m_freq);
    chk("nco_reset", int'(nco_reset), m_nco);
    chk("busy", int'(busy), (m_mode == 1 || m_mode == 2) ? 1 : 0);
    chk("done", int'(done), (m_mode == 3) ? 1 : 0);
    chk("note_idx", int'(note_idx), m_idx);
    if (done) done_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic write_entry(input int a, input int f, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_freq = (N-1)'(f); wr_dur = DUR_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_seq(input int l, input int p);
    len = (AW+1)'(l); presc = PRESC_W'(p); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until the model is in LOAD of the given entry; expired bound is a failure
  task automatic wait_load(input int idx);
    int cnt = 0;
    while (!(m_mode == 1 && m_idx == idx) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("wait_load_bound", (cnt < 200) ? 1 : 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; wr_en = 1'b0;
    len = '0; presc = '0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
    m_mode = 0; m_freq = 0; m_nco = 1; m_idx = 0; m_el = 0;
    m_len = 0; m_presc = 0; m_nlen = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin m_tf[i] = 0; m_td[i] = 0; end

    // Reset held two cycles, then idle
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_nco_reset", int'(nco_reset), 1);
    chk("rst_busy", int'(busy), 0);
    repeat (50) tick();

    // One-shot two-note sequence
    write_entry(0, 5, 0);
    write_entry(1, 9, 1);
    done_seen = 0;
    start_seq(2, 2);
    tick();
    chk("oneshot_first_freq", int'(freq_out), 5);
    repeat (40) tick();
    chk("oneshot_done_count", done_seen, 1);
    chk("oneshot_idle_nco", int'(nco_reset), 1);

    // Looping, then clearing loop during the last note
    loop = 1'b1; done_seen = 0;
    start_seq(2, 2);
    repeat (50) tick();
    chk("loop_no_done", done_seen, 0);
    wait_load(1);
    tick();
    loop = 1'b0;
    repeat (30) tick();
    chk("loop_clear_done", done_seen, 1);
    chk("loop_clear_busy", int'(busy), 0);

    // Stop mid-note and start+stop together
    done_seen = 0;
    start_seq(2, 2);
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_nco", int'(nco_reset), 1);
    repeat (5) tick();
    chk("stop_no_done", done_seen, 0);
    start = 1'b1; stop = 1'b1; len = 4'd2;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    chk("startstop_idle", int'(busy), 0);

    // Write collision with LOAD of entry 1
    loop = 1'b1;
    start_seq(2, 2);
    wait_load(1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_freq = 4'd3; wr_dur = 4'd1;
    tick();
    wr_en = 1'b0;
    chk("collide_old", int'(freq_out), 9);
    wait_load(1);
    tick();
    chk("collide_new", int'(freq_out), 3);
    stop = 1'b1; loop = 1'b0;
    tick();
    stop = 1'b0;

    // len = 0 ignored; presc = 0 steps every cycle
    start_seq(0, 1);
    chk("len0_ignored", int'(busy), 0);
    start_seq(1, 0);
    tick();
    chk("presc0_step_a", int'(step), 1);
    tick();
    chk("presc0_step_b", int'(step), 1);
    repeat (10) tick();

    // Reset mid-play clears the table
    start_seq(2, 1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    start_seq(2, 0);
    tick();
    chk("replay_freq_zero", int'(freq_out), 0);
    chk("replay_nco_run", int'(nco_reset), 0);
    repeat (20) tick();

    // Random traffic
    for (int c = 0; c < 15000; c++) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = AW'($urandom);
      wr_freq = (N-1)'($urandom);
      wr_dur  = DUR_W'($urandom_range(0, 3));
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      len     = (AW+1)'($urandom);
      presc   = PRESC_W'($urandom_range(0, 3));
      rst_n   = ($urandom_range(0, 999) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
